// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  typedef logic [WB_ADDR_W-1:0] reg_idx_t;
  typedef logic [WB_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_idx_t  rd;
    reg_data_t data;
  } wb_req_t;

  localparam reg_idx_t REG_ZERO = '0;

  // x0 is hardwired, so a result aimed at it never reaches the port.
  function automatic logic writes_reg(reg_idx_t rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO holding load results until the write port is free.
module wb_load_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_data,
  input  logic                     pop,
  output wb_req_t                  pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  wb_req_t             mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                do_push, do_pop;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port controller: ALU/load arbitration plus load scoreboard.
// Optional bypass outputs are enabled with REGFILE_WB_FWD_EN.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = WB_ADDR_W,
  parameter int unsigned DATA_WIDTH    = WB_DATA_W,
  parameter int unsigned LQ_DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     issue_valid,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs1,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic                     fwd_valid,
  output logic [ADDRESS_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]    fwd_data
`endif
);

  localparam int unsigned NumRegs = 1 << ADDRESS_WIDTH;

  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;
  logic [NumRegs-1:0]       sb_q, sb_d;

  wb_req_t                  lq_push_data, lq_head;
  logic                     lq_push, lq_pop, lq_full, lq_empty;
  logic [$clog2(LQ_DEPTH):0] lq_count;
  logic                     sb_clr;

  assign mem_ready    = !lq_full;
  assign lq_push      = mem_valid && mem_ready;
  assign lq_push_data = '{rd: mem_rd, data: mem_data};

  wb_load_fifo #(
    .Depth (LQ_DEPTH)
  ) u_load_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lq_push),
    .push_data (lq_push_data),
    .pop       (lq_pop),
    .pop_data  (lq_head),
    .full      (lq_full),
    .empty     (lq_empty),
    .count     (lq_count)
  );

  always_comb begin
    we_d   = 1'b0;
    ad_d   = ad_q;
    wd_d   = wd_q;
    sb_d   = sb_q;
    lq_pop = 1'b0;
    sb_clr = 1'b0;
    if (alu_valid) begin
      if (writes_reg(alu_rd)) begin
        we_d = 1'b1;
        ad_d = alu_rd;
        wd_d = alu_data;
      end
    end else if (!lq_empty) begin
      // Dropped x0 loads still consume their entry.
      lq_pop = 1'b1;
      sb_clr = 1'b1;
      sb_d[lq_head.rd] = 1'b0;
      if (writes_reg(lq_head.rd)) begin
        we_d = 1'b1;
        ad_d = lq_head.rd;
        wd_d = lq_head.data;
      end
    end
    // Applied after the clear so a same-cycle reissue keeps the bit set.
    if (issue_valid && writes_reg(issue_rd)) begin
      sb_d[issue_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      ad_q <= '0;
      wd_q <= '0;
      sb_q <= '0;
    end else begin
      we_q <= we_d;
      ad_q <= ad_d;
      wd_q <= wd_d;
      sb_q <= sb_d;
    end
  end

  assign WE3   = we_q;
  assign AD3   = ad_q;
  assign WD3   = wd_q;
  assign busy1 = sb_q[chk_rs1];
  assign busy2 = sb_q[chk_rs2];

`ifdef REGFILE_WB_FWD_EN
  assign fwd_valid = we_q && writes_reg(ad_q);
  assign fwd_rd    = ad_q;
  assign fwd_data  = wd_q;
`endif

  // A reissue is legal only when the prior load retires in the same cycle.
  issue_to_busy_reg : assert property (@(posedge clk) disable iff (rst)
    (issue_valid && writes_reg(issue_rd)) |->
      (!sb_q[issue_rd] || (sb_clr && lq_head.rd == issue_rd)));

  alu_waw_on_busy_reg : assert property (@(posedge clk) disable iff (rst)
    (alu_valid && writes_reg(alu_rd)) |-> !sb_q[alu_rd]);

  lq_count_in_range : assert property (@(posedge clk) disable iff (rst)
    lq_count <= ($clog2(LQ_DEPTH) + 1)'(LQ_DEPTH));

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed plus randomized bench for regfile_writeback against a queue-based model.
module tb_regfile_writeback;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, issue_valid;
  logic [AW-1:0] alu_rd, mem_rd, issue_rd, chk_rs1, chk_rs2;
  logic [DW-1:0] alu_data, mem_data;
  logic          mem_ready, busy1, busy2, WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;

  regfile_writeback #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .LQ_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .busy1       (busy1),
    .busy2       (busy2),
    .WE3         (WE3),
    .AD3         (AD3),
    .WD3         (WD3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  bit            busy_m[32];
  logic          exp_we;
  logic [AW-1:0] exp_ad;
  logic [DW-1:0] exp_wd;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next-cycle prediction from the arbitration/scoreboard rules.
  task automatic model_update();
    ent_t h;
    bit   push;
    if (rst) begin
      mq.delete();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      exp_we = 1'b0;
      exp_ad = '0;
      exp_wd = '0;
    end else begin
      push   = mem_valid && (mq.size() < DEPTH);
      exp_we = 1'b0;
      if (alu_valid) begin
        if (alu_rd != 0) begin
          exp_we = 1'b1;
          exp_ad = alu_rd;
          exp_wd = alu_data;
        end
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        busy_m[h.rd] = 1'b0;
        if (h.rd != 0) begin
          exp_we = 1'b1;
          exp_ad = h.rd;
          exp_wd = h.data;
        end
      end
      if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
      if (push) mq.push_back('{rd: mem_rd, data: mem_data});
    end
  endtask

  task automatic step(string tag);
    #1;
    chk({tag, " mem_ready"}, 64'(mem_ready), 64'(mq.size() < DEPTH));
    chk({tag, " busy1"}, 64'(busy1), 64'(busy_m[chk_rs1]));
    chk({tag, " busy2"}, 64'(busy2), 64'(busy_m[chk_rs2]));
    model_update();
    @(posedge clk);
    #1;
    chk({tag, " WE3"}, 64'(WE3), 64'(exp_we));
    if (exp_we) begin
      chk({tag, " AD3"}, 64'(AD3), 64'(exp_ad));
      chk({tag, " WD3"}, 64'(WD3), 64'(exp_wd));
    end
  endtask

  task automatic idle();
    rst         = 1'b0;
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
    issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    exp_we = 1'b0; exp_ad = '0; exp_wd = '0;
    @(posedge clk);
    #1;

    // Reset
    rst = 1'b1;
    step("rst0");
    step("rst1");
    chk("rst AD3", 64'(AD3), 64'd0);
    chk("rst WD3", 64'(WD3), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk_rs1 = AW'(i);
      chk_rs2 = AW'(31 - i);
      #1;
      chk("rst busy1", 64'(busy1), 64'd0);
      chk("rst busy2", 64'(busy2), 64'd0);
    end

    // ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step("alu");
    chk("alu AD3", 64'(AD3), 64'd5);
    chk("alu WD3", 64'(WD3), 64'hDEADBEEF);
    idle();

    // Load with scoreboard
    chk_rs1 = 5'd7; chk_rs2 = 5'd5;
    issue_valid = 1'b1; issue_rd = 5'd7;
    step("ld_issue");
    idle();
    step("ld_wait0");
    step("ld_wait1");
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
    step("ld_push");
    idle();
    chk("ld busy1 pending", 64'(busy1), 64'd1);
    step("ld_pop");
    chk("ld AD3", 64'(AD3), 64'd7);
    chk("ld WD3", 64'(WD3), 64'h1234);
    chk("ld busy1 cleared", 64'(busy1), 64'd0);
    step("ld_idle");

    // Contention: queued load yields to four ALU writes
    chk_rs1 = 5'd3; chk_rs2 = 5'd21;
    issue_valid = 1'b1; issue_rd = 5'd3;
    step("ct_iss3");
    issue_rd = 5'd20;
    step("ct_iss20");
    issue_rd = 5'd21;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    step("ct_push3");
    issue_valid = 1'b0;
    mem_rd = 5'd20; mem_data = 32'h2020;
    alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = AW'(10 + i); alu_data = 32'hA000 + 32'(i);
      if (i == 1) begin
        chk("ct mem_ready full", 64'(mem_ready), 64'd0);
        mem_rd = 5'd21; mem_data = 32'h2121;
      end
      step("ct_alu");
    end
    alu_valid = 1'b0;
    step("ct_load3");
    chk("ct AD3 load", 64'(AD3), 64'd3);
    step("ct_accept21");
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("ct_drain");

    // x0 handling and same-cycle set/clear
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    step("x0_alu");
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h5555;
    step("x0_push");
    mem_valid = 1'b0;
    step("x0_pop");
    chk_rs1 = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    step("sim_iss9");
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    step("sim_push9");
    mem_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    step("sim_pop_reissue9");
    chk("sim busy9 kept", 64'(busy1), 64'd1);
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h999;
    step("sim_push9b");
    mem_valid = 1'b0;
    step("sim_pop9b");
    step("sim_idle");

    // Mid-operation reset with a full FIFO and two busy bits
    chk_rs1 = 5'd14; chk_rs2 = 5'd15;
    issue_valid = 1'b1; issue_rd = 5'd14;
    step("mr_iss14");
    issue_rd = 5'd15;
    step("mr_iss15");
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 32'hE;
    step("mr_fill0");
    alu_rd = 5'd2; mem_rd = 5'd15; mem_data = 32'hF;
    step("mr_fill1");
    chk("mr full", 64'(mem_ready), 64'd0);
    idle();
    rst = 1'b1;
    step("mr_rst");
    chk("mr WE3", 64'(WE3), 64'd0);
    rst = 1'b0;
    #1;
    chk("mr mem_ready", 64'(mem_ready), 64'd1);
    chk("mr busy14", 64'(busy1), 64'd0);
    chk("mr busy15", 64'(busy2), 64'd0);
    step("mr_after");

    // Randomized traffic obeying the decode hazard rules
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_rd      = AW'($urandom_range(0, 31));
      alu_data    = $urandom;
      if (busy_m[alu_rd]) alu_rd = '0;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = AW'($urandom_range(0, 31));
      if (busy_m[issue_rd]) issue_valid = 1'b0;
      mem_valid   = ($urandom_range(0, 1) == 0);
      mem_rd      = AW'($urandom_range(0, 31));
      mem_data    = $urandom;
      chk_rs1     = AW'($urandom_range(0, 31));
      chk_rs2     = AW'($urandom_range(0, 31));
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
